// File: rtl/alu_chain_seq.sv
// ============================================================================
// Module   : alu_chain_seq
// Purpose  : Sequencer that walks one shared ALU through a multi-word
//            ADDX/SUBX chain, least-significant word first. It carries X
//            between words, accumulates Z across the chain and reports final
//            68k-style XNZVC flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_chain_seq #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  // command channel
  input  logic          in_cmd_valid,
  output logic          out_cmd_ready,
  input  logic [3:0]    in_cmd_OP,
  input  logic [CW-1:0] in_cmd_COUNT,
  input  logic          in_cmd_X,
  // operand channel
  input  logic          in_opd_valid,
  output logic          out_opd_ready,
  input  logic [N-1:0]  in_opd_A,
  input  logic [N-1:0]  in_opd_B,
  // result channel
  output logic          out_res_valid,
  input  logic          in_res_ready,
  output logic [N-1:0]  out_res_DATA,
  output logic          out_res_LAST,
  // status
  output logic          out_done,
  output logic          out_err,
  output logic [4:0]    out_XNZVC,
  // shared ALU interface
  output logic [N-1:0]  out_alu_A,
  output logic [N-1:0]  out_alu_B,
  output logic [3:0]    out_alu_OP,
  output logic          out_alu_X,
  input  logic [4:0]    in_alu_XNZVC,
  input  logic [N-1:0]  in_alu_RES
);

  // ALU opcodes accepted for chaining
  localparam logic [3:0] OP_ADDX = 4'h4;
  localparam logic [3:0] OP_SUBX = 4'h5;

  // Flag bit positions inside an XNZVC vector
  localparam int BITPOS_X = 4;
  localparam int BITPOS_N = 3;
  localparam int BITPOS_Z = 2;
  localparam int BITPOS_V = 1;
  localparam int BITPOS_C = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic          x_reg;
  logic          z_acc;
  logic          n_last;
  logic          v_last;
  logic          c_last;

  logic          cmd_legal;
  logic [4:0]    chain_flags;

  // A command is only worth starting if it names a chaining op and has work
  always_comb begin
    cmd_legal = 1'b0;
    if ((in_cmd_COUNT != '0) &&
        ((in_cmd_OP == OP_ADDX) || (in_cmd_OP == OP_SUBX))) begin
      cmd_legal = 1'b1;
    end
  end

  // Assemble the final chain flags into their architectural bit positions
  always_comb begin
    chain_flags           = 5'b0;
    chain_flags[BITPOS_X] = x_reg;
    chain_flags[BITPOS_N] = n_last;
    chain_flags[BITPOS_Z] = z_acc;
    chain_flags[BITPOS_V] = v_last;
    chain_flags[BITPOS_C] = c_last;
  end

  // The running X feeds the ALU directly so it settles during EXEC
  assign out_alu_X = x_reg;

  // Chain sequencer: state, datapath registers and all handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      out_cmd_ready <= 1'b1;
      out_opd_ready <= 1'b0;
      out_res_valid <= 1'b0;
      out_res_DATA  <= '0;
      out_res_LAST  <= 1'b0;
      out_done      <= 1'b0;
      out_err       <= 1'b0;
      out_XNZVC     <= 5'b0;
      out_alu_A     <= '0;
      out_alu_B     <= '0;
      out_alu_OP    <= 4'h0;
      remaining     <= '0;
      x_reg         <= 1'b0;
      z_acc         <= 1'b0;
      n_last        <= 1'b0;
      v_last        <= 1'b0;
      c_last        <= 1'b0;
    end else begin
      // pulses default low and are raised only for the cycle they mark
      out_err  <= 1'b0;
      out_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_cmd_valid) begin
            if (cmd_legal) begin
              out_alu_OP    <= in_cmd_OP;
              remaining     <= in_cmd_COUNT;
              x_reg         <= in_cmd_X;
              z_acc         <= 1'b1;
              out_cmd_ready <= 1'b0;
              out_opd_ready <= 1'b1;
              state         <= S_FETCH;
            end else begin
              out_err <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (in_opd_valid) begin
            out_alu_A     <= in_opd_A;
            out_alu_B     <= in_opd_B;
            out_opd_ready <= 1'b0;
            state         <= S_EXEC;
          end
        end

        S_EXEC: begin
          // ALU has settled on the registered operands and current X
          out_res_DATA  <= in_alu_RES;
          out_res_LAST  <= (remaining == CW'(1));
          out_res_valid <= 1'b1;
          x_reg         <= in_alu_XNZVC[BITPOS_X];
          z_acc         <= z_acc & in_alu_XNZVC[BITPOS_Z];
          n_last        <= in_alu_XNZVC[BITPOS_N];
          v_last        <= in_alu_XNZVC[BITPOS_V];
          c_last        <= in_alu_XNZVC[BITPOS_C];
          state         <= S_WRITE;
        end

        S_WRITE: begin
          if (in_res_ready) begin
            out_res_valid <= 1'b0;
            out_res_LAST  <= 1'b0;
            remaining     <= remaining - CW'(1);
            if (out_res_LAST) begin
              out_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              out_opd_ready <= 1'b1;
              state         <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          out_XNZVC     <= chain_flags;
          out_cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          out_cmd_ready <= 1'b1;
          out_opd_ready <= 1'b0;
          out_res_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_chain_seq.sv
// ============================================================================
// Module   : tb_alu_chain_seq
// Purpose  : Self-checking bench for alu_chain_seq with an ALU model, a
//            whole-chain arithmetic reference and a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_chain_seq;

  localparam int N    = 32;
  localparam int CW   = 8;
  localparam int MAXW = 255;
  localparam int BW   = MAXW * N;

  localparam logic [3:0] OP_ADDX = 4'h4;
  localparam logic [3:0] OP_SUBX = 4'h5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_cmd_valid;
  logic          out_cmd_ready;
  logic [3:0]    in_cmd_OP;
  logic [CW-1:0] in_cmd_COUNT;
  logic          in_cmd_X;
  logic          in_opd_valid;
  logic          out_opd_ready;
  logic [N-1:0]  in_opd_A;
  logic [N-1:0]  in_opd_B;
  logic          out_res_valid;
  logic          in_res_ready;
  logic [N-1:0]  out_res_DATA;
  logic          out_res_LAST;
  logic          out_done;
  logic          out_err;
  logic [4:0]    out_XNZVC;
  logic [N-1:0]  out_alu_A;
  logic [N-1:0]  out_alu_B;
  logic [3:0]    out_alu_OP;
  logic          out_alu_X;
  logic [4:0]    in_alu_XNZVC;
  logic [N-1:0]  in_alu_RES;

  alu_chain_seq #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .in_cmd_OP(in_cmd_OP), .in_cmd_COUNT(in_cmd_COUNT), .in_cmd_X(in_cmd_X),
    .in_opd_valid(in_opd_valid), .out_opd_ready(out_opd_ready),
    .in_opd_A(in_opd_A), .in_opd_B(in_opd_B),
    .out_res_valid(out_res_valid), .in_res_ready(in_res_ready),
    .out_res_DATA(out_res_DATA), .out_res_LAST(out_res_LAST),
    .out_done(out_done), .out_err(out_err), .out_XNZVC(out_XNZVC),
    .out_alu_A(out_alu_A), .out_alu_B(out_alu_B),
    .out_alu_OP(out_alu_OP), .out_alu_X(out_alu_X),
    .in_alu_XNZVC(in_alu_XNZVC), .in_alu_RES(in_alu_RES)
  );

  always #5 clk = ~clk;

  // Combinational single-word ALU: ADDX/SUBX with X in, XNZVC out
  logic [N:0] alu_w;
  logic       alu_v;
  always_comb begin
    alu_w = '0;
    alu_v = 1'b0;
    if (out_alu_OP == OP_SUBX) begin
      alu_w = {1'b0, out_alu_A} - {1'b0, out_alu_B} - {{N{1'b0}}, out_alu_X};
      alu_v = (out_alu_A[N-1] != out_alu_B[N-1]) && (alu_w[N-1] != out_alu_A[N-1]);
    end else begin
      alu_w = {1'b0, out_alu_A} + {1'b0, out_alu_B} + {{N{1'b0}}, out_alu_X};
      alu_v = (out_alu_A[N-1] == out_alu_B[N-1]) && (alu_w[N-1] != out_alu_A[N-1]);
    end
    in_alu_RES   = alu_w[N-1:0];
    in_alu_XNZVC = {alu_w[N], alu_w[N-1], (alu_w[N-1:0] == '0), alu_v, alu_w[N]};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  bit hold_ready = 1'b0;

  logic [N-1:0] exp_data[$];
  logic         exp_last[$];
  logic [4:0]   exp_flags[$];
  logic [N-1:0] a_q[$];
  logic [N-1:0] b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: treat the whole chain as one wide integer add/subtract
  logic [BW:0] ra, rb, rr;
  task automatic model_chain(input logic [3:0] op, input int cnt, input logic x);
    logic z, c, n, v, sa, sb;
    ra = '0;
    rb = '0;
    for (int i = 0; i < cnt; i++) begin
      ra[i*N +: N] = a_q[i];
      rb[i*N +: N] = b_q[i];
    end
    if (op == OP_SUBX) rr = ra - rb - {{BW{1'b0}}, x};
    else               rr = ra + rb + {{BW{1'b0}}, x};
    z = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      exp_data.push_back(rr[i*N +: N]);
      exp_last.push_back(i == cnt - 1);
      if (rr[i*N +: N] != '0) z = 1'b0;
    end
    c  = rr[cnt*N];
    n  = rr[cnt*N-1];
    sa = ra[cnt*N-1];
    sb = rb[cnt*N-1];
    v  = (op == OP_SUBX) ? ((sa != sb) && (n != sa)) : ((sa == sb) && (n != sa));
    exp_flags.push_back({c, n, z, v, c});
  endtask

  // Consumer ready: random back-pressure unless a hold is requested
  initial begin
    in_res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      in_res_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expectations on each result handshake, done pulse and err
  initial begin
    logic       pend;
    logic [4:0] pend_flags;
    pend = 1'b0;
    pend_flags = 5'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("final_xnzvc", {59'b0, out_XNZVC}, {59'b0, pend_flags});
        pend = 1'b0;
      end
      if (!reset) begin
        if (out_err) err_seen++;
        if (out_res_valid && in_res_ready) begin
          if (exp_data.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: got %h expected none", out_res_DATA);
          end else begin
            chk("res_data", {32'b0, out_res_DATA}, {32'b0, exp_data.pop_front()});
            chk("res_last", {63'b0, out_res_LAST}, {63'b0, exp_last.pop_front()});
          end
        end
        if (out_done) begin
          if (exp_flags.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            pend_flags = exp_flags.pop_front();
            pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_cmd_ready(output bit ok);
    int t = 0;
    while (!out_cmd_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    ok = out_cmd_ready;
    if (!ok) timeout_fail("cmd_ready_wait");
  endtask

  // Issue a legal chain using a_q/b_q; optionally offer a stray command
  // during the operand phase, which must be ignored
  task automatic run_chain(input logic [3:0] op, input int cnt, input logic x, input bit noise);
    bit ok;
    int t;
    model_chain(op, cnt, x);
    wait_cmd_ready(ok);
    if (!ok) return;
    in_cmd_valid = 1'b1; in_cmd_OP = op; in_cmd_COUNT = CW'(cnt); in_cmd_X = x;
    @(posedge clk); #1;
    in_cmd_valid = 1'b0;
    if (noise) begin
      in_cmd_valid = 1'b1; in_cmd_OP = OP_ADDX; in_cmd_COUNT = 8'd1; in_cmd_X = 1'b0;
    end
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      t = 0;
      while (!out_opd_ready && t < 2000) begin @(posedge clk); #1; t++; end
      if (!out_opd_ready) begin timeout_fail("opd_ready_wait"); break; end
      in_opd_valid = 1'b1; in_opd_A = a_q[i]; in_opd_B = b_q[i];
      @(posedge clk); #1;
      in_opd_valid = 1'b0;
      in_opd_A = $urandom; in_opd_B = $urandom;
    end
    in_cmd_valid = 1'b0;
    wait_cmd_ready(ok);
  endtask

  task automatic reject_cmd(input logic [3:0] op, input int cnt);
    bit ok;
    wait_cmd_ready(ok);
    in_cmd_valid = 1'b1; in_cmd_OP = op; in_cmd_COUNT = CW'(cnt); in_cmd_X = 1'b1;
    @(posedge clk); #1;
    in_cmd_valid = 1'b0;
    err_exp++;
    chk("reject_err_pulse", {63'b0, out_err}, 64'd1);
    chk("reject_stays_idle", {63'b0, out_cmd_ready}, 64'd1);
    @(posedge clk); #1;
    chk("reject_err_one_cycle", {63'b0, out_err}, 64'd0);
    chk("reject_no_fetch", {63'b0, out_opd_ready}, 64'd0);
  endtask

  task automatic set_words(input logic [N-1:0] a0, input logic [N-1:0] b0,
                           input logic [N-1:0] a1, input logic [N-1:0] b1, input int cnt);
    a_q.delete(); b_q.delete();
    a_q.push_back(a0); b_q.push_back(b0);
    if (cnt > 1) begin a_q.push_back(a1); b_q.push_back(b1); end
  endtask

  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int t;
    logic [N-1:0] held;
    reset = 1'b1;
    in_cmd_valid = 1'b0; in_cmd_OP = 4'h0; in_cmd_COUNT = '0; in_cmd_X = 1'b0;
    in_opd_valid = 1'b0; in_opd_A = '0; in_opd_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {63'b0, out_cmd_ready}, 64'd1);
    chk("rst_opd_ready", {63'b0, out_opd_ready}, 64'd0);
    chk("rst_res_valid", {63'b0, out_res_valid}, 64'd0);
    chk("rst_done", {63'b0, out_done}, 64'd0);
    chk("rst_err", {63'b0, out_err}, 64'd0);
    chk("rst_xnzvc", {59'b0, out_XNZVC}, 64'd0);
    chk("rst_res_data", {32'b0, out_res_DATA}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed single-word cases
    set_words(32'h0000_0001, 32'h0, '0, '0, 1);           run_chain(OP_ADDX, 1, 1'b0, 1'b0);
    set_words(32'hF000_0000, 32'h8000_0000, '0, '0, 1);   run_chain(OP_ADDX, 1, 1'b0, 1'b0);
    set_words(32'h7FFF_FFFF, 32'h0000_0010, '0, '0, 1);   run_chain(OP_ADDX, 1, 1'b0, 1'b0);

    // reset during EXEC drops the chain and clears the flags
    wait_cmd_ready(ok);
    in_cmd_valid = 1'b1; in_cmd_OP = OP_ADDX; in_cmd_COUNT = 8'd2; in_cmd_X = 1'b1;
    @(posedge clk); #1;
    in_cmd_valid = 1'b0;
    in_opd_valid = 1'b1; in_opd_A = 32'h1234_5678; in_opd_B = 32'h1111_1111;
    @(posedge clk); #1;
    in_opd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("exec_rst_cmd_ready", {63'b0, out_cmd_ready}, 64'd1);
    chk("exec_rst_xnzvc", {59'b0, out_XNZVC}, 64'd0);
    chk("exec_rst_res_valid", {63'b0, out_res_valid}, 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("exec_rst_no_done", {63'b0, out_done}, 64'd0);
    end

    // multi-word carry propagation and Z accumulation
    set_words(32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2);      run_chain(OP_ADDX, 2, 1'b0, 1'b0);
    set_words(32'h0, 32'h0, 32'h0, 32'h0, 2);              run_chain(OP_ADDX, 2, 1'b0, 1'b0);
    set_words(32'h5, 32'h0, 32'h0, 32'h0, 2);              run_chain(OP_ADDX, 2, 1'b0, 1'b0);
    set_words(32'h0, 32'h1, 32'h0, 32'h0, 2);              run_chain(OP_SUBX, 2, 1'b0, 1'b0);

    // rejected commands
    reject_cmd(OP_ADDX, 0);
    reject_cmd(4'h0, 3);

    // result held back: data stable, no operand accepted meanwhile
    hold_ready = 1'b1;
    set_words(32'hDEAD_BEEF, 32'h0101_0101, 32'h2, 32'h3, 2);
    fork
      run_chain(OP_ADDX, 2, 1'b1, 1'b0);
      begin
        t = 0;
        while (!out_res_valid && t < 200) begin @(posedge clk); #1; t++; end
        if (!out_res_valid) timeout_fail("hold_valid_wait");
        held = out_res_DATA;
        repeat (5) begin
          @(posedge clk); #1;
          chk("hold_data_stable", {32'b0, out_res_DATA}, {32'b0, held});
          chk("hold_valid", {63'b0, out_res_valid}, 64'd1);
          chk("hold_no_opd", {63'b0, out_opd_ready}, 64'd0);
        end
        hold_ready = 1'b0;
      end
    join

    // randomized chains, some with a stray command offered mid-chain
    for (int k = 0; k < 30; k++) begin
      int cnt;
      cnt = $urandom_range(1, 6);
      a_q.delete(); b_q.delete();
      for (int i = 0; i < cnt; i++) begin
        a_q.push_back(rand_word());
        b_q.push_back(rand_word());
      end
      run_chain(($urandom_range(0, 1) != 0) ? OP_SUBX : OP_ADDX, cnt,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // full-length chain
    a_q.delete(); b_q.delete();
    for (int i = 0; i < MAXW; i++) begin
      a_q.push_back(rand_word());
      b_q.push_back(rand_word());
    end
    run_chain(OP_SUBX, MAXW, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("all_results_seen", 64'(exp_data.size()), 64'd0);
    chk("all_done_seen", 64'(exp_flags.size()), 64'd0);
    chk("err_pulse_count", 64'(err_seen), 64'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
